// File: rtl/fnd_scan_decoder.sv
// Recovers a 4-digit hex frame by watching a multiplexed, active-low 7-segment bus.
// Define FND_DEC_SYNC_EN to route the bus through a two-flop synchronizer first.
module fnd_scan_decoder #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [3:0]  i_FND_Digit,
    input  logic [7:0]  i_FND_Font,
    output logic [15:0] o_Value,
    output logic [3:0]  o_DP,
    output logic        o_Valid,
    output logic        o_Error
);

    localparam int CNT_W = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 2);

    typedef enum logic {SETTLE, HOLD} state_t;

    logic [3:0]       w_dig;
    logic [7:0]       w_font;
    logic [4:0]       w_dec;
    logic             w_dp;
    logic             w_same;
    logic             w_eval;
    logic             w_single;
    logic             w_cap;
    logic             w_err;
    logic [3:0]       w_cap_bit;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [3:0]       r_prev_dig;
    logic [7:0]       r_prev_font;
    logic [3:0]       r_mask;
    logic [15:0]      r_shadow_val;
    logic [3:0]       r_shadow_dp;

`ifdef FND_DEC_SYNC_EN
    logic [3:0] r_dig_s1, r_dig_s2;
    logic [7:0] r_font_s1, r_font_s2;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_dig_s1  <= 4'hF;
            r_dig_s2  <= 4'hF;
            r_font_s1 <= 8'hFF;
            r_font_s2 <= 8'hFF;
        end else begin
            r_dig_s1  <= i_FND_Digit;
            r_dig_s2  <= r_dig_s1;
            r_font_s1 <= i_FND_Font;
            r_font_s2 <= r_font_s1;
        end
    end

    assign w_dig  = r_dig_s2;
    assign w_font = r_font_s2;
`else
    assign w_dig  = i_FND_Digit;
    assign w_font = i_FND_Font;
`endif

    // Returns {valid, nibble}; segment inputs are active-low {g,f,e,d,c,b,a}.
    function automatic logic [4:0] decode_font(input logic [6:0] seg);
        case (seg)
            7'h40:   decode_font = 5'h10;
            7'h79:   decode_font = 5'h11;
            7'h24:   decode_font = 5'h12;
            7'h30:   decode_font = 5'h13;
            7'h19:   decode_font = 5'h14;
            7'h12:   decode_font = 5'h15;
            7'h02:   decode_font = 5'h16;
            7'h78:   decode_font = 5'h17;
            7'h00:   decode_font = 5'h18;
            7'h10:   decode_font = 5'h19;
            7'h08:   decode_font = 5'h1A;
            7'h03:   decode_font = 5'h1B;
            7'h46:   decode_font = 5'h1C;
            7'h21:   decode_font = 5'h1D;
            7'h06:   decode_font = 5'h1E;
            7'h0E:   decode_font = 5'h1F;
            default: decode_font = 5'h00;
        endcase
    endfunction

    always_comb begin
        w_dec    = decode_font(w_font[6:0]);
        w_dp     = ~w_font[7];
        w_same   = ({w_dig, w_font} == {r_prev_dig, r_prev_font});
        w_eval   = w_same && (r_state == SETTLE) && (r_cnt == CNT_LAST);
        w_single = (w_dig == 4'b1110) || (w_dig == 4'b1101) ||
                   (w_dig == 4'b1011) || (w_dig == 4'b0111);
        w_cap    = w_eval && w_single && w_dec[4];
        w_err    = w_eval && (w_dig != 4'hF) && !(w_single && w_dec[4]);
        w_cap_bit = w_cap ? ~w_dig : 4'b0000;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state      <= SETTLE;
            r_cnt        <= '0;
            r_prev_dig   <= 4'hF;
            r_prev_font  <= 8'hFF;
            r_mask       <= 4'b0000;
            r_shadow_val <= 16'h0000;
            r_shadow_dp  <= 4'b0000;
            o_Value      <= 16'h0000;
            o_DP         <= 4'b0000;
            o_Valid      <= 1'b0;
            o_Error      <= 1'b0;
        end else begin
            r_prev_dig  <= w_dig;
            r_prev_font <= w_font;

            if (!w_same) begin
                r_state <= SETTLE;
                r_cnt   <= '0;
            end else if (r_state == SETTLE) begin
                if (r_cnt == CNT_LAST)
                    r_state <= HOLD;
                else
                    r_cnt <= r_cnt + CNT_W'(1);
            end

            o_Error <= w_err;
            o_Valid <= (r_mask == 4'hF);
            if (r_mask == 4'hF) begin
                o_Value <= r_shadow_val;
                o_DP    <= r_shadow_dp;
            end

            // A capture landing on the clearing cycle seeds the next frame.
            r_mask <= ((r_mask == 4'hF) ? 4'b0000 : r_mask) | w_cap_bit;
            for (int i = 0; i < 4; i++) begin
                if (w_cap_bit[i]) begin
                    r_shadow_val[4*i +: 4] <= w_dec[3:0];
                    r_shadow_dp[i]         <= w_dp;
                end
            end
        end
    end

endmodule

// File: tb/tb_fnd_scan_decoder.sv
// Directed bench for fnd_scan_decoder: frame table plus hand-written corner sequences.
module tb_fnd_scan_decoder;

    localparam int STABLE_CYCLES = 4;
`ifdef FND_DEC_SYNC_EN
    localparam int LAT = STABLE_CYCLES + 3;
`else
    localparam int LAT = STABLE_CYCLES + 1;
`endif

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic [3:0]  i_FND_Digit;
    logic [7:0]  i_FND_Font;
    logic [15:0] o_Value;
    logic [3:0]  o_DP;
    logic        o_Valid;
    logic        o_Error;

    fnd_scan_decoder #(.STABLE_CYCLES(STABLE_CYCLES)) dut (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_FND_Digit (i_FND_Digit),
        .i_FND_Font  (i_FND_Font),
        .o_Value     (o_Value),
        .o_DP        (o_DP),
        .o_Valid     (o_Valid),
        .o_Error     (o_Error)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [15:0] digs;   // step k digit pattern in [4k+3:4k]
        logic [31:0] fonts;  // step k font in [8k+7:8k]
        logic [15:0] val;
        logic [3:0]  dp;
    } frame_t;

    frame_t frames[4];
    int checks = 0;
    int errors = 0;
    int valid_cnt;
    int err_cnt;
    int last_valid_k;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Inputs change 1 time unit after a rising edge; edge k is the k-th edge after that.
    task automatic present(input logic [3:0] d, input logic [7:0] f, input int cycles);
        i_FND_Digit  = d;
        i_FND_Font   = f;
        last_valid_k = 0;
        for (int k = 1; k <= cycles; k++) begin
            @(posedge i_clk);
            #1;
            if (o_Valid) begin
                valid_cnt++;
                last_valid_k = k;
            end
            if (o_Error) err_cnt++;
        end
    endtask

    task automatic clr_counts();
        valid_cnt = 0;
        err_cnt   = 0;
    endtask

    initial begin
        frames[0] = '{digs: 16'h7BDE, fonts: 32'h99B0A4F9, val: 16'h4321, dp: 4'b0000};
        frames[1] = '{digs: 16'h7BDE, fonts: 32'hC6A1860E, val: 16'hCDEF, dp: 4'b0001};
        frames[2] = '{digs: 16'hEDB7, fonts: 32'h089000C0, val: 16'h089A, dp: 4'b0101};
        frames[3] = '{digs: 16'h7BDE, fonts: 32'hF8829283, val: 16'h765B, dp: 4'b0000};

        i_reset     = 1'b1;
        i_FND_Digit = 4'hF;
        i_FND_Font  = 8'hFF;
        repeat (3) @(posedge i_clk);
        #1;
        chk("reset_value", 32'(o_Value), 32'h0);
        chk("reset_dp",    32'(o_DP),    32'h0);
        chk("reset_valid", 32'(o_Valid), 32'h0);
        chk("reset_error", 32'(o_Error), 32'h0);
        i_reset = 1'b0;
        present(4'hF, 8'hFF, 4);

        for (int n = 0; n < 4; n++) begin
            clr_counts();
            for (int s = 0; s < 4; s++)
                present(frames[n].digs[4*s +: 4], frames[n].fonts[8*s +: 8], 8);
            chk($sformatf("frame%0d_valid_cnt", n), 32'(valid_cnt), 32'd1);
            chk($sformatf("frame%0d_err_cnt", n),   32'(err_cnt),   32'd0);
            chk($sformatf("frame%0d_value", n),     32'(o_Value),   32'(frames[n].val));
            chk($sformatf("frame%0d_dp", n),        32'(o_DP),      32'(frames[n].dp));
            if (n == 0) chk("frame0_latency", 32'(last_valid_k), 32'(LAT));
        end

        // Font flips every 2 cycles: never stable long enough to capture digit 0.
        clr_counts();
        for (int i = 0; i < 10; i++) begin
            present(4'b1110, 8'hC0, 2);
            present(4'b1110, 8'hF9, 2);
        end
        present(4'b1101, 8'hA4, 8);
        present(4'b1011, 8'hB0, 8);
        present(4'b0111, 8'h99, 8);
        chk("unstable_no_valid", 32'(valid_cnt), 32'd0);
        chk("unstable_no_error", 32'(err_cnt),   32'd0);
        chk("unstable_value_held", 32'(o_Value), 32'h765B);

        clr_counts();
        present(4'b1110, 8'hFF, 8);
        chk("bad_font_error", 32'(err_cnt),   32'd1);
        chk("bad_font_valid", 32'(valid_cnt), 32'd0);
        clr_counts();
        present(4'b1100, 8'hC0, 8);
        chk("two_digits_error", 32'(err_cnt),   32'd1);
        chk("two_digits_valid", 32'(valid_cnt), 32'd0);
        clr_counts();
        present(4'b1111, 8'hFF, 8);
        chk("blank_error", 32'(err_cnt),   32'd0);
        chk("blank_valid", 32'(valid_cnt), 32'd0);

        // Slots 1..3 kept from before the rejected samples; digit 0 completes them.
        clr_counts();
        present(4'b1110, 8'hF9, 8);
        chk("resume_valid", 32'(valid_cnt), 32'd1);
        chk("resume_value", 32'(o_Value),   32'h4321);
        chk("resume_dp",    32'(o_DP),      32'h0);

        // Partial frame then reset: only digit 3 afterwards must not complete anything.
        clr_counts();
        present(4'b1110, 8'hC0, 8);
        present(4'b1101, 8'hF9, 8);
        present(4'b1011, 8'hA4, 8);
        i_reset = 1'b1;
        @(posedge i_clk);
        #1;
        chk("midreset_value", 32'(o_Value), 32'h0);
        chk("midreset_dp",    32'(o_DP),    32'h0);
        i_reset = 1'b0;
        clr_counts();
        present(4'b0111, 8'h99, 16);
        chk("after_reset_valid", 32'(valid_cnt), 32'd0);
        chk("after_reset_error", 32'(err_cnt),   32'd0);
        chk("after_reset_value", 32'(o_Value),   32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, checks %0d errors %0d", checks, errors);
        $fatal(1);
    end

endmodule
